// File: rtl/systolic_skew_feeder_if.sv
// Load-side handshake and pe_array drive bundle for systolic_skew_feeder.
// Every bus packs lane 0 into its most significant element.
interface systolic_skew_feeder_if #(
    parameter int BITWIDTH = 8,
    parameter int X_ROW    = 3,
    parameter int Y_COL    = 3
);
    logic                      load_valid;
    logic                      load_ready;
    logic [X_ROW*BITWIDTH-1:0] load_a_col;
    logic [Y_COL*BITWIDTH-1:0] load_b_row;
    logic                      arr_rst_n;
    logic                      arr_en;
    logic [X_ROW*BITWIDTH-1:0] out_row;
    logic [Y_COL*BITWIDTH-1:0] out_col;
    logic                      busy;
    logic                      done;

    modport slave (
        input  load_valid, load_a_col, load_b_row,
        output load_ready, arr_rst_n, arr_en, out_row, out_col, busy, done
    );

    modport master (
        output load_valid, load_a_col, load_b_row,
        input  load_ready, arr_rst_n, arr_en, out_row, out_col, busy, done
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers A (X_ROW x K) and B (K x Y_COL) and streams them diagonally skewed into pe_array.
// Define SKEW_FEEDER_PINGPONG_EN for two operand banks so the next matrix loads during a run.

// One lane of the skew: emits vec[t - LANE] inside the K-beat window, zero elsewhere.
module skew_lane #(
    parameter int BITWIDTH = 8,
    parameter int K_DEPTH  = 3,
    parameter int LANE     = 0,
    parameter int TW       = 4
) (
    input  logic [TW-1:0]                     t,
    input  logic [K_DEPTH-1:0][BITWIDTH-1:0]  vec,
    output logic [BITWIDTH-1:0]               dout
);
    always_comb begin
        dout = '0;
        for (int k = 0; k < K_DEPTH; k++)
            if (int'(t) == k + LANE) dout = vec[k];
    end
endmodule

module systolic_skew_feeder #(
    parameter int BITWIDTH = 8,
    parameter int X_ROW    = 3,
    parameter int Y_COL    = 3,
    parameter int K_DEPTH  = 3,
    parameter int PE_LAT   = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    systolic_skew_feeder_if.slave bus
);
    localparam int RUN_LEN = K_DEPTH + X_ROW + Y_COL - 2 + PE_LAT;
    localparam int KW      = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;
    localparam int TW      = $clog2(RUN_LEN + 1);
`ifdef SKEW_FEEDER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CLEAR = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [TW-1:0] t, t_nx;
    logic          lb, rb;      // bank being filled / bank being streamed
    logic          acc, last, ready_nx;

    // per lane, packed over k so a lane module sees its whole operand row/column
    logic [K_DEPTH-1:0][BITWIDTH-1:0] a_mem [NB][X_ROW];
    logic [K_DEPTH-1:0][BITWIDTH-1:0] b_mem [NB][Y_COL];

    // ascending packed range puts lane 0 in the MSBs, matching the bus packing
    logic [0:X_ROW-1][BITWIDTH-1:0] row_nx;
    logic [0:Y_COL-1][BITWIDTH-1:0] col_nx;

    assign acc  = bus.load_valid && bus.load_ready;
    assign last = acc && (k == KW'(K_DEPTH - 1));

`ifdef SKEW_FEEDER_PINGPONG_EN
    logic full, full_nx, lb_nx, rb_nx;
`else
    assign lb = 1'b0;
    assign rb = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int i = 0; i < X_ROW; i++)
                a_mem[lb][i][k] <= bus.load_a_col[(X_ROW-i)*BITWIDTH-1 -: BITWIDTH];
            for (int j = 0; j < Y_COL; j++)
                b_mem[lb][j][k] <= bus.load_b_row[(Y_COL-j)*BITWIDTH-1 -: BITWIDTH];
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        t_nx     = t;
`ifdef SKEW_FEEDER_PINGPONG_EN
        full_nx  = full;
        lb_nx    = lb;
        rb_nx    = rb;
`endif
        if (acc) k_nx = last ? '0 : k + 1'b1;
        case (state)
            IDLE, LOAD: begin
                if (last) begin
                    state_nx = CLEAR;
`ifdef SKEW_FEEDER_PINGPONG_EN
                    rb_nx = lb;
                    lb_nx = ~lb;
`endif
                end else if (acc) begin
                    state_nx = LOAD;
                end
            end
            CLEAR: begin
                state_nx = RUN;
                t_nx     = '0;
            end
            RUN: begin
                if (t == TW'(RUN_LEN - 1)) state_nx = DONE;
                else                       t_nx     = t + 1'b1;
            end
            DONE: begin
`ifdef SKEW_FEEDER_PINGPONG_EN
                // a bank completed during the run goes straight into the next CLEAR
                if (full || last) begin
                    state_nx = CLEAR;
                    rb_nx    = lb;
                    lb_nx    = ~lb;
                    full_nx  = 1'b0;
                end else begin
                    state_nx = (k_nx != '0) ? LOAD : IDLE;
                end
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
`ifdef SKEW_FEEDER_PINGPONG_EN
        if (last && (state == CLEAR || state == RUN)) full_nx = 1'b1;
        ready_nx = (state_nx == IDLE) || (state_nx == LOAD) || !full_nx;
`else
        ready_nx = (state_nx == IDLE) || (state_nx == LOAD);
`endif
    end

    for (genvar i = 0; i < X_ROW; i++) begin : g_row
        skew_lane #(.BITWIDTH(BITWIDTH), .K_DEPTH(K_DEPTH), .LANE(i), .TW(TW)) u_lane (
            .t(t_nx), .vec(a_mem[rb][i]), .dout(row_nx[i])
        );
    end

    for (genvar j = 0; j < Y_COL; j++) begin : g_col
        skew_lane #(.BITWIDTH(BITWIDTH), .K_DEPTH(K_DEPTH), .LANE(j), .TW(TW)) u_lane (
            .t(t_nx), .vec(b_mem[rb][j]), .dout(col_nx[j])
        );
    end

    // outputs are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            k              <= '0;
            t              <= '0;
            bus.load_ready <= 1'b1;
            bus.arr_rst_n  <= 1'b0;
            bus.arr_en     <= 1'b0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
`ifdef SKEW_FEEDER_PINGPONG_EN
            full           <= 1'b0;
            lb             <= 1'b0;
            rb             <= 1'b0;
`endif
        end else begin
            state          <= state_nx;
            k              <= k_nx;
            t              <= t_nx;
            bus.load_ready <= ready_nx;
            bus.arr_en     <= (state_nx == RUN);
            bus.busy       <= (state_nx == CLEAR) || (state_nx == RUN);
            bus.done       <= (state_nx == DONE);
            bus.out_row    <= (state_nx == RUN) ? row_nx : '0;
            bus.out_col    <= (state_nx == RUN) ? col_nx : '0;
            // array stays cleared until the first run, then holds results after it
            if (state_nx == CLEAR)    bus.arr_rst_n <= 1'b0;
            else if (state_nx == RUN) bus.arr_rst_n <= 1'b1;
`ifdef SKEW_FEEDER_PINGPONG_EN
            full           <= full_nx;
            lb             <= lb_nx;
            rb             <= rb_nx;
`endif
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench: per-cycle timeline model of the feeder plus literal stream/result checks.
module tb_systolic_skew_feeder;
    localparam int BW = 8, X = 3, Y = 3, K = 3, PL = 1;
    localparam int RL = K + X + Y - 2 + PL;
    localparam int MAXC = 400;
`ifdef SKEW_FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef int mat_t [3][3];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.BITWIDTH(BW), .X_ROW(X), .Y_COL(Y)) bus ();
    systolic_skew_feeder #(.BITWIDTH(BW), .X_ROW(X), .Y_COL(Y), .K_DEPTH(K), .PE_LAT(PL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int last_done = -1;

    // expected outputs indexed by cycle number (cycle n = interval after the n-th edge)
    logic [X*BW-1:0] e_row [MAXC];
    logic [Y*BW-1:0] e_col [MAXC];
    bit e_rdy [MAXC], e_rstn [MAXC], e_en [MAXC], e_busy [MAXC], e_done [MAXC];

    mat_t A1 = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mat_t B1 = '{'{3, 2, 1}, '{6, 5, 4}, '{9, 8, 7}};
`ifdef SKEW_FEEDER_PINGPONG_EN
    mat_t A2 = '{'{17, 18, 19}, '{20, 33, 34}, '{250, 1, 128}};
    mat_t B2 = '{'{5, 6, 7}, '{200, 0, 9}, '{11, 12, 255}};
`endif

    logic [23:0] lit_row [8] = '{24'h010000, 24'h020400, 24'h030507, 24'h000608,
                                 24'h000009, 24'h000000, 24'h000000, 24'h000000};
    logic [23:0] lit_col [8] = '{24'h030000, 24'h060200, 24'h090501, 24'h000804,
                                 24'h000007, 24'h000000, 24'h000000, 24'h000000};
    int lit_c [3][3] = '{'{42, 36, 30}, '{96, 81, 66}, '{150, 126, 102}};

    function automatic void apply_reset(input int r);
        for (int cy = r; cy < MAXC; cy++) begin
            e_row[cy] = '0; e_col[cy] = '0; e_rdy[cy] = 1'b1; e_rstn[cy] = 1'b0;
            e_en[cy] = 1'b0; e_busy[cy] = 1'b0; e_done[cy] = 1'b0;
        end
        last_done = -1;
    endfunction

    // lane i carries A[i][t-i]; lane j carries B[t-j][j]
    function automatic logic [X*BW-1:0] skew_a(input mat_t A, input int t);
        logic [X*BW-1:0] v = '0;
        for (int i = 0; i < X; i++)
            if (t - i >= 0 && t - i < K) v[(X-i)*BW-1 -: BW] = BW'(A[i][t-i]);
        return v;
    endfunction

    function automatic logic [Y*BW-1:0] skew_b(input mat_t B, input int t);
        logic [Y*BW-1:0] v = '0;
        for (int j = 0; j < Y; j++)
            if (t - j >= 0 && t - j < K) v[(Y-j)*BW-1 -: BW] = BW'(B[t-j][j]);
        return v;
    endfunction

    function automatic void schedule_run(input int c, input mat_t A, input mat_t B);
        int d = c + 1 + RL;
        for (int cy = c; cy < MAXC; cy++) begin
            e_row[cy] = '0; e_col[cy] = '0; e_en[cy] = 1'b0; e_busy[cy] = 1'b0; e_done[cy] = 1'b0;
            e_rstn[cy] = (cy > c);
            e_rdy[cy] = (cy > d) ? 1'b1 : PP;
            if (cy == c) e_busy[cy] = 1'b1;
            else if (cy < d) begin
                e_busy[cy] = 1'b1; e_en[cy] = 1'b1;
                e_row[cy] = skew_a(A, cy - c - 1);
                e_col[cy] = skew_b(B, cy - c - 1);
            end else if (cy == d) e_done[cy] = 1'b1;
        end
    endfunction

    // last beat taken at edge e: returns the CLEAR cycle of that matrix
    function automatic int model_last(input int e, input mat_t A, input mat_t B);
        int clr = e;
        if (e <= last_done) begin
            clr = last_done + 1;
            for (int cy = e; cy <= last_done; cy++) e_rdy[cy] = 1'b0;
        end
        schedule_run(clr, A, B);
        last_done = clr + 1 + RL;
        return clr;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        int g = 0;
        while (cyc < target && g < 1000) begin step(); g++; end
        if (cyc != target) chk("wait_bound", cyc, target);
    endtask

    task automatic load_matrix(input mat_t A, input mat_t B, input int stall_after, output int clr);
        for (int k = 0; k < K; k++) begin
            bit acc = 1'b0;
            int g = 0;
            bus.load_valid = 1'b1;
            for (int i = 0; i < X; i++) bus.load_a_col[(X-i)*BW-1 -: BW] = BW'(A[i][k]);
            for (int j = 0; j < Y; j++) bus.load_b_row[(Y-j)*BW-1 -: BW] = BW'(B[k][j]);
            while (!acc && g < 200 && cyc < MAXC) begin acc = e_rdy[cyc]; step(); g++; end
            bus.load_valid = 1'b0;
            if (!acc) chk("load_accept_bound", 0, 1);
            if (k == stall_after) repeat (4) step();
        end
        clr = model_last(cyc, A, B);
    endtask

    // literal stream of testing case 1, plus a pe_array accumulation of the observed streams
    task automatic check_test1(input int c);
        int rr [8][3];
        int cc [8][3];
        wait_until(c + 1);
        for (int t = 0; t < 8; t++) begin
            chk($sformatf("row_t%0d", t), int'(bus.out_row), int'(lit_row[t]));
            chk($sformatf("col_t%0d", t), int'(bus.out_col), int'(lit_col[t]));
            for (int l = 0; l < 3; l++) begin
                rr[t][l] = int'(bus.out_row[(3-l)*BW-1 -: BW]);
                cc[t][l] = int'(bus.out_col[(3-l)*BW-1 -: BW]);
            end
            if (t < 7) step();
        end
        wait_until(c + 1 + RL);
        chk("done_pulse", int'(bus.done), 1);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int t = 0; t < 8; t++)
                    if (t - j >= 0 && t - i >= 0) s += rr[t-j][i] * cc[t-i][j];
                chk($sformatf("pe_c%0d%0d", i, j), s, lit_c[i][j]);
            end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            n_tests++;
            if (bus.load_ready !== e_rdy[cyc] || bus.arr_rst_n !== e_rstn[cyc] ||
                bus.arr_en !== e_en[cyc] || bus.busy !== e_busy[cyc] ||
                bus.done !== e_done[cyc] || bus.out_row !== e_row[cyc] ||
                bus.out_col !== e_col[cyc]) begin
                n_fail++;
                $display("FAIL timeline @cyc %0d: got rdy%b rstn%b en%b busy%b done%b row %h col %h, expected rdy%b rstn%b en%b busy%b done%b row %h col %h",
                         cyc, bus.load_ready, bus.arr_rst_n, bus.arr_en, bus.busy, bus.done,
                         bus.out_row, bus.out_col, e_rdy[cyc], e_rstn[cyc], e_en[cyc],
                         e_busy[cyc], e_done[cyc], e_row[cyc], e_col[cyc]);
            end
        end
    end

    initial begin
        int c;
        bus.load_valid = 1'b0;
        bus.load_a_col = '0;
        bus.load_b_row = '0;
        apply_reset(1);
        step();
        chk_en = 1'b1;
        chk("rst_ready", int'(bus.load_ready), 1);
        chk("rst_arr_rst_n", int'(bus.arr_rst_n), 0);
        chk("rst_en", int'(bus.arr_en), 0);
        chk("rst_busy_done", int'({bus.busy, bus.done}), 0);
        chk("rst_buses", int'(bus.out_row | bus.out_col), 0);
        step();
        rst_n = 1'b1;
        step();

        // plain 3x3x3 load
        load_matrix(A1, B1, -1, c);
        check_test1(c);
        step();

        // stalled load: four idle cycles between beats 1 and 2
        load_matrix(A1, B1, 1, c);
        check_test1(c);

        // reset in the middle of a run, then a fresh load
        load_matrix(A1, B1, -1, c);
        wait_until(c + 3);
        rst_n = 1'b0;
        step();
        apply_reset(cyc);
        chk("midrst_ready", int'(bus.load_ready), 1);
        chk("midrst_arr_rst_n", int'(bus.arr_rst_n), 0);
        chk("midrst_en", int'(bus.arr_en), 0);
        chk("midrst_buses", int'(bus.out_row | bus.out_col), 0);
        rst_n = 1'b1;
        step();
        load_matrix(A1, B1, -1, c);
        check_test1(c);

`ifndef SKEW_FEEDER_PINGPONG_EN
        // beats offered during a run must be ignored
        load_matrix(A1, B1, -1, c);
        fork
            check_test1(c);
            begin
                wait_until(c + 2);
                bus.load_valid = 1'b1;
                bus.load_a_col = 24'hFFEEDD;
                bus.load_b_row = 24'hCCBBAA;
                repeat (3) step();
                bus.load_valid = 1'b0;
            end
        join
        load_matrix(A1, B1, -1, c);
        check_test1(c);
`else
        // second matrix loads during the first run; CLEAR follows DONE directly
        begin
            int c1, c2;
            load_matrix(A2, B2, -1, c1);
            load_matrix(A1, B1, -1, c2);
            wait_until(c1 + 1 + RL);
            chk("pp_done1", int'(bus.done), 1);
            step();
            chk("pp_clear_busy", int'(bus.busy), 1);
            chk("pp_clear_rst_n", int'(bus.arr_rst_n), 0);
            check_test1(c2);
            chk("pp_done2_spacing", int'(bus.done) * (cyc - (c1 + 1 + RL)), RL + 2);
        end
`endif

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
